// File: rtl/mem_read_req.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_req
// Brief    : Burst read requester for fixed-latency read-only memories. Issues
//            one credit-checked read per cycle and returns the responses in
//            order through a first-word-fall-through FIFO. Defining
//            MEM_READ_REQ_PERF_EN builds the issue-stall cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_req #(
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start,
  input  logic [31:0]         base_addr,
  input  logic [CNT_BITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic [31:0]         addr,
  output logic                addr_valid,
  input  logic [31:0]         mem_val_in,
  input  logic                mem_valid_in,
  output logic [31:0]         out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic [31:0]         stall_cycles
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(FIFO_DEPTH);

  if (MEM_LAT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("mem_read_req: illegal MEM_LAT or FIFO_DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_done_set;
  logic                  r_done;
  logic [31:0]           r_next_addr;
  logic [31:0]           r_addr_hold;
  logic [CNT_BITS-1:0]   r_remaining;
  logic [CNT_BITS-1:0]   r_count;
  logic [CNT_BITS-1:0]   r_ret_cnt;
  logic [c_CNT_W-1:0]    r_outstanding;
  logic [c_CNT_W-1:0]    r_fifo_cnt;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];

  logic                  w_credit;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_last;
  logic [c_CNT_W-1:0]    w_fifo_cnt_next;
  logic [c_CNT_W-1:0]    w_out_next;

  // In-flight reads plus buffered words may never exceed the FIFO capacity.
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < c_DEPTH_EXT;
  assign w_issue     = (r_state == ISSUE) && (r_remaining != '0) && w_credit;
  assign w_push      = mem_valid_in && (r_state != IDLE);
  assign w_pop       = out_valid && out_ready;
  assign w_push_last = (r_ret_cnt + CNT_BITS'(1)) == r_count;

  assign w_fifo_cnt_next = r_fifo_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
  assign w_out_next      = r_outstanding + c_CNT_W'(w_issue) - c_CNT_W'(w_push);

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign addr_valid = w_issue;
  assign addr       = w_issue ? r_next_addr : r_addr_hold;
  assign out_valid  = (r_fifo_cnt != '0);
  assign out_data   = out_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign out_last   = out_valid && r_fifo_last[r_rd_ptr];

  always_comb begin
    w_state_next = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (count == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (w_issue && (r_remaining == CNT_BITS'(1))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Look ahead so done lands in the cycle right after the final handshake.
        if ((w_out_next == '0) && (w_fifo_cnt_next == '0)) begin
          w_state_next = IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= IDLE;
      r_done        <= 1'b0;
      r_next_addr   <= '0;
      r_addr_hold   <= '0;
      r_remaining   <= '0;
      r_count       <= '0;
      r_ret_cnt     <= '0;
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_done        <= w_done_set;
      r_outstanding <= w_out_next;
      r_fifo_cnt    <= w_fifo_cnt_next;
      if ((r_state == IDLE) && start) begin
        r_next_addr <= base_addr;
        r_remaining <= count;
        r_count     <= count;
        r_ret_cnt   <= '0;
      end
      if (w_issue) begin
        r_addr_hold <= r_next_addr;
        r_next_addr <= r_next_addr + 32'd1;
        r_remaining <= r_remaining - CNT_BITS'(1);
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
        r_ret_cnt <= r_ret_cnt + CNT_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_val_in;
      r_fifo_last[r_wr_ptr] <= w_push_last;
    end
  end

`ifdef MEM_READ_REQ_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ISSUE) && (r_remaining != '0) && !w_credit &&
                 (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

`ifndef SYNTHESIS
  a_fifo_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(w_push && !w_pop && (r_fifo_cnt == c_DEPTH_CNT)));
`endif

endmodule
`default_nettype wire
